// File: rtl/imem_loader.sv
// ============================================================================
//  imem_loader : fills the instruction memory from a framed byte stream and
//                holds the CPU in reset until the image is complete.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [16:0]       DEPTH    = 17'(2 ** ADDR_W);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;

  logic              accept;
  logic [15:0]       hdr_n;
  logic [16:0]       next_word;
  logic [IDLE_W-1:0] idle_inc;

  assign accept    = rx_valid && rx_ready_q;
  assign hdr_n     = {cnt_q[15:8], rx_data};
  assign next_word = 17'(word_idx_q) + 17'd1;
  assign idle_inc  = idle_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    idle_d     = idle_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    case (state_q)
      S_HDR_HI: begin
        idle_d = '0;
        if (accept) begin
          cnt_d[15:8] = rx_data;
          state_d     = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        if (accept) begin
          idle_d     = '0;
          cnt_d[7:0] = rx_data;
          if (hdr_n == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, hdr_n} > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end else if (idle_inc == IDLE_MAX) begin
          idle_d  = '0;
          state_d = S_ERR;
        end else begin
          idle_d = idle_inc;
        end
      end

      S_DATA: begin
        if (accept) begin
          idle_d     = '0;
          byte_idx_d = byte_idx_q + 2'd1;
          asm_d      = {asm_q[15:0], rx_data};
          if (byte_idx_q == 2'd3) begin
            mem_we_d   = 1'b1;
            mem_addr_d = word_idx_q[ADDR_W-1:0];
            mem_din_d  = {asm_q, rx_data};
            word_idx_d = word_idx_q + 1'b1;
            // DONE is entered in the same cycle the final write is presented.
            if (next_word == {1'b0, cnt_q}) begin
              state_d = S_DONE;
            end
          end
        end else if (idle_inc == IDLE_MAX) begin
          idle_d  = '0;
          state_d = S_ERR;
        end else begin
          idle_d = idle_inc;
        end
      end

      S_DONE, S_ERR: begin
        if (load_start) begin
          state_d    = S_HDR_HI;
          word_idx_d = '0;
          byte_idx_d = '0;
          idle_d     = '0;
        end
      end

      default: begin
        state_d = S_HDR_HI;
      end
    endcase

    rx_ready_d   = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_DATA);
    cpu_hold_d   = (state_d != S_DONE);
    load_done_d  = (state_d == S_DONE);
    load_error_d = (state_d == S_ERR);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_HDR_HI;
      cnt_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      idle_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      rx_ready_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      idle_q       <= idle_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      rx_ready_q   <= rx_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  tb_imem_loader : directed test sequence for imem_loader.
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic              clock;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              load_start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  int vectors = 0;
  int errors  = 0;

  // write log, filled by the monitor below
  int                wn = 0;
  logic [ADDR_W-1:0] wlog_addr [8];
  logic [31:0]       wlog_data [8];
  int                long_pulse = 0;
  logic              we_prev = 1'b0;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .load_start (load_start),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      if (wn < 8) begin
        wlog_addr[wn] = mem_addr;
        wlog_data[wn] = mem_din;
      end
      wn = wn + 1;
      if (we_prev) long_pulse = long_pulse + 1;
    end
    we_prev = (mem_we === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves rx_valid high one cycle later so consecutive calls stream back-to-back.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) check("ready_wait", {31'd0, rx_ready}, 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] f2 [12];
    logic       ready_ok;

    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; load_start = 1'b0;
    repeat (3) @(negedge clock);

    // reset state
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_addr",   {22'd0, mem_addr},   32'd0);
    check("rst_mem_din",    mem_din,             32'd0);
    check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("rst_load_done",  {31'd0, load_done},  32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);
    check("rst_rx_ready",   {31'd0, rx_ready},   32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rel_rx_ready",   {31'd0, rx_ready},   32'd1);

    // 1: two-word image
    wn = 0;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hAC); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    check("t1_done_with_last_we", {31'd0, load_done}, 32'd1);
    repeat (3) @(negedge clock);
    check("t1_nwrites",   wn,            32'd2);
    check("t1_addr0",     {22'd0, wlog_addr[0]}, 32'd0);
    check("t1_data0",     wlog_data[0],  32'h20010005);
    check("t1_addr1",     {22'd0, wlog_addr[1]}, 32'd1);
    check("t1_data1",     wlog_data[1],  32'hAC010000);
    check("t1_cpu_hold",  {31'd0, cpu_hold},  32'd0);
    check("t1_load_done", {31'd0, load_done}, 32'd1);
    check("t1_rx_ready",  {31'd0, rx_ready},  32'd0);

    // 2: back-to-back three-word image
    pulse_start();
    check("t2_restart_hold", {31'd0, cpu_hold},  32'd1);
    check("t2_restart_done", {31'd0, load_done}, 32'd0);
    wn = 0;
    f2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    ready_ok = 1'b1;
    send_byte(8'h00); send_byte(8'h03);
    for (int i = 0; i < 12; i++) begin
      send_byte(f2[i]);
      if (i < 11 && rx_ready !== 1'b1) ready_ok = 1'b0;
    end
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("t2_ready_in_data", {31'd0, ready_ok}, 32'd1);
    check("t2_nwrites", wn, 32'd3);
    check("t2_addr0", {22'd0, wlog_addr[0]}, 32'd0);
    check("t2_data0", wlog_data[0], 32'h11223344);
    check("t2_addr1", {22'd0, wlog_addr[1]}, 32'd1);
    check("t2_data1", wlog_data[1], 32'h55667788);
    check("t2_addr2", {22'd0, wlog_addr[2]}, 32'd2);
    check("t2_data2", wlog_data[2], 32'h99AABBCC);
    check("t2_load_done", {31'd0, load_done}, 32'd1);

    // 3: empty image
    pulse_start();
    wn = 0;
    send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    check("t3_done",     {31'd0, load_done}, 32'd1);
    check("t3_cpu_hold", {31'd0, cpu_hold},  32'd0);
    repeat (3) @(negedge clock);
    check("t3_nwrites", wn, 32'd0);

    // 4: oversize count
    pulse_start();
    wn = 0;
    send_byte(8'h04); send_byte(8'h01);
    rx_valid = 1'b0;
    check("t4_error",    {31'd0, load_error}, 32'd1);
    check("t4_cpu_hold", {31'd0, cpu_hold},   32'd1);
    check("t4_rx_ready", {31'd0, rx_ready},   32'd0);
    repeat (3) @(negedge clock);
    check("t4_nwrites", wn, 32'd0);
    pulse_start();
    check("t4_err_clear", {31'd0, load_error}, 32'd0);
    check("t4_ready_back", {31'd0, rx_ready},  32'd1);

    // 5: stall mid-frame until timeout
    wn = 0;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h42);
    rx_valid = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clock);
    check("t5_no_err_early", {31'd0, load_error}, 32'd0);
    @(negedge clock);
    check("t5_err",      {31'd0, load_error}, 32'd1);
    check("t5_cpu_hold", {31'd0, cpu_hold},   32'd1);
    check("t5_nwrites",  wn, 32'd1);
    check("t5_addr0",    {22'd0, wlog_addr[0]}, 32'd0);
    check("t5_data0",    wlog_data[0], 32'hDEADBEEF);

    // 6: reset mid-word, then a fresh frame
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
    rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst_mem_we",   {31'd0, mem_we},     32'd0);
    check("t6_rst_addr",     {22'd0, mem_addr},   32'd0);
    check("t6_rst_din",      mem_din,             32'd0);
    check("t6_rst_hold",     {31'd0, cpu_hold},   32'd1);
    check("t6_rst_done",     {31'd0, load_done},  32'd0);
    check("t6_rst_error",    {31'd0, load_error}, 32'd0);
    check("t6_rst_ready",    {31'd0, rx_ready},   32'd0);
    reset = 1'b1;
    @(negedge clock);
    wn = 0;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_nwrites", wn, 32'd1);
    check("t6_addr0",   {22'd0, wlog_addr[0]}, 32'd0);
    check("t6_data0",   wlog_data[0], 32'hCAFEBABE);
    check("t6_done",    {31'd0, load_done}, 32'd1);

    check("we_single_cycle", long_pulse, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
